// File: rtl/vga_pkg.sv
// Shared VGA definitions: visible-area constants, color indices, fill FSM states.
package vga_pkg;

  localparam int HD         = 1280;
  localparam int VD         = 1024;
  localparam int FB_X_W     = 11;
  localparam int FB_Y_W     = 11;
  localparam int FB_COLOR_W = 2;

  typedef enum logic [FB_COLOR_W-1:0] {
    BLACK = 2'd0,
    WHITE = 2'd1,
    BLUE  = 2'd2,
    GREEN = 2'd3
  } color_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_t;

  // Owner of the most recent contested write slot.
  typedef enum logic {
    RR_HOST = 1'b0,
    RR_FILL = 1'b1
  } rr_owner_t;

endpackage

// File: rtl/fb_rect_walker.sv
// Raster walker for the fill engine: clamps the rectangle to the visible area,
// flags empty rectangles, and steps x/y one pixel per advance.
module fb_rect_walker #(
  parameter int X_W     = 11,
  parameter int Y_W     = 11,
  parameter int HD      = 1280,
  parameter int VD      = 1024,
  parameter int COLOR_W = 2
) (
  input  logic               i_clk,
  input  logic               i_arst,
  input  logic               i_load,
  input  logic [X_W-1:0]     i_x0,
  input  logic [X_W-1:0]     i_x1,
  input  logic [Y_W-1:0]     i_y0,
  input  logic [Y_W-1:0]     i_y1,
  input  logic [COLOR_W-1:0] i_color,
  input  logic               i_advance,
  output logic               o_empty,
  output logic               o_valid,
  output logic               o_last,
  output logic [X_W-1:0]     o_x,
  output logic [Y_W-1:0]     o_y,
  output logic [COLOR_W-1:0] o_color
);

  localparam logic [X_W-1:0] X_MAX = X_W'(HD - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(VD - 1);

  logic [X_W-1:0]     w_x1c;
  logic [Y_W-1:0]     w_y1c;
  logic [X_W-1:0]     r_x0;
  logic [X_W-1:0]     r_x1c;
  logic [Y_W-1:0]     r_y1c;
  logic [X_W-1:0]     r_x;
  logic [Y_W-1:0]     r_y;
  logic [COLOR_W-1:0] r_color;
  logic               r_valid;

  // Clamp the far corner and detect rectangles that produce no pixels.
  always_comb begin
    w_x1c   = (i_x1 > X_MAX) ? X_MAX : i_x1;
    w_y1c   = (i_y1 > Y_MAX) ? Y_MAX : i_y1;
    o_empty = (i_x0 > w_x1c) || (i_y0 > w_y1c) || (i_x0 > X_MAX) || (i_y0 > Y_MAX);
  end

  // Raster counters: compare against the clamped bound before stepping, so they never wrap.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_x0    <= '0;
      r_x1c   <= '0;
      r_y1c   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_color <= '0;
      r_valid <= 1'b0;
    end else if (i_load && !o_empty) begin
      r_x0    <= i_x0;
      r_x1c   <= w_x1c;
      r_y1c   <= w_y1c;
      r_x     <= i_x0;
      r_y     <= i_y0;
      r_color <= i_color;
      r_valid <= 1'b1;
    end else if (i_advance && r_valid) begin
      if (o_last) begin
        r_valid <= 1'b0;
      end else if (r_x == r_x1c) begin
        r_x <= r_x0;
        r_y <= r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_last  = r_valid && (r_x == r_x1c) && (r_y == r_y1c);
  assign o_x     = r_x;
  assign o_y     = r_y;
  assign o_color = r_color;

endmodule

// File: rtl/fb_write_arbiter.sv
// Framebuffer write-port arbiter: shares one registered write port between host
// pixel writes and the rectangle-fill engine, round-robin on contested cycles.
//
// state | meaning
// IDLE  | no fill active; host owns the port
// FILL  | walker emitting pixels; contested cycles alternate host/fill
// DONE  | fill finished; fill_done_o pulses for this one cycle
module fb_write_arbiter #(
  parameter int X_W     = vga_pkg::FB_X_W,
  parameter int Y_W     = vga_pkg::FB_Y_W,
  parameter int HD      = vga_pkg::HD,
  parameter int VD      = vga_pkg::VD,
  parameter int COLOR_W = vga_pkg::FB_COLOR_W
) (
  input  logic               clk_i,
  input  logic               arst_i,
  input  logic               host_req_i,
  input  logic [X_W-1:0]     host_x_i,
  input  logic [Y_W-1:0]     host_y_i,
  input  logic [COLOR_W-1:0] host_color_i,
  output logic               host_gnt_o,
  input  logic               fill_start_i,
  input  logic [X_W-1:0]     fill_x0_i,
  input  logic [X_W-1:0]     fill_x1_i,
  input  logic [Y_W-1:0]     fill_y0_i,
  input  logic [Y_W-1:0]     fill_y1_i,
  input  logic [COLOR_W-1:0] fill_color_i,
  output logic               fill_busy_o,
  output logic               fill_done_o,
  output logic               fb_we_o,
  output logic [X_W-1:0]     fb_addr_x_o,
  output logic [Y_W-1:0]     fb_addr_y_o,
  output logic [COLOR_W-1:0] fb_color_o
);
  import vga_pkg::*;

  localparam logic [X_W-1:0] X_MAX = X_W'(HD - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(VD - 1);

  fill_state_t        r_state, w_state_nxt;
  rr_owner_t          r_rr_last, w_rr_nxt;
  logic               w_load;
  logic               w_empty;
  logic               w_valid;
  logic               w_last;
  logic               w_fill_gnt;
  logic               w_host_ok;
  logic [X_W-1:0]     w_fx;
  logic [Y_W-1:0]     w_fy;
  logic [COLOR_W-1:0] w_fc;
  logic               r_we;
  logic [X_W-1:0]     r_x;
  logic [Y_W-1:0]     r_y;
  logic [COLOR_W-1:0] r_color;

  assign w_load    = (r_state == IDLE) && fill_start_i;
  assign w_host_ok = (host_x_i <= X_MAX) && (host_y_i <= Y_MAX);

  fb_rect_walker #(
    .X_W    (X_W),
    .Y_W    (Y_W),
    .HD     (HD),
    .VD     (VD),
    .COLOR_W(COLOR_W)
  ) u_walker (
    .i_clk    (clk_i),
    .i_arst   (arst_i),
    .i_load   (w_load),
    .i_x0     (fill_x0_i),
    .i_x1     (fill_x1_i),
    .i_y0     (fill_y0_i),
    .i_y1     (fill_y1_i),
    .i_color  (fill_color_i),
    .i_advance(w_fill_gnt),
    .o_empty  (w_empty),
    .o_valid  (w_valid),
    .o_last   (w_last),
    .o_x      (w_fx),
    .o_y      (w_fy),
    .o_color  (w_fc)
  );

  // State and round-robin history registers.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state   <= IDLE;
      r_rr_last <= RR_FILL;
    end else begin
      r_state   <= w_state_nxt;
      r_rr_last <= w_rr_nxt;
    end
  end

  // Next state and per-cycle grant; rr history moves only when both sides want the port.
  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_last;
    host_gnt_o  = host_req_i;
    w_fill_gnt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (fill_start_i) w_state_nxt = w_empty ? DONE : FILL;
      end
      FILL: begin
        if (!host_req_i) begin
          w_fill_gnt = w_valid;
        end else if (r_rr_last == RR_FILL) begin
          w_rr_nxt = RR_HOST;
        end else begin
          host_gnt_o = 1'b0;
          w_fill_gnt = w_valid;
          w_rr_nxt   = RR_FILL;
        end
        if (w_fill_gnt && w_last) w_state_nxt = DONE;
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Write port register: one cycle behind the grant; off-screen host writes are swallowed.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_we    <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_color <= '0;
    end else if (host_gnt_o) begin
      r_we    <= w_host_ok;
      r_x     <= host_x_i;
      r_y     <= host_y_i;
      r_color <= host_color_i;
    end else if (w_fill_gnt) begin
      r_we    <= 1'b1;
      r_x     <= w_fx;
      r_y     <= w_fy;
      r_color <= w_fc;
    end else begin
      r_we    <= 1'b0;
    end
  end

  assign fill_busy_o = (r_state != IDLE);
  assign fill_done_o = (r_state == DONE);
  assign fb_we_o     = r_we;
  assign fb_addr_x_o = r_x;
  assign fb_addr_y_o = r_y;
  assign fb_color_o  = r_color;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter: directed scenarios followed by random
// host/fill traffic, compared cycle by cycle with a pixel-list reference model.
module tb_fb_write_arbiter;

  localparam int HD = 1280;
  localparam int VD = 1024;

  logic        clk_i = 1'b0;
  logic        arst_i;
  logic        host_req_i;
  logic [10:0] host_x_i;
  logic [10:0] host_y_i;
  logic [1:0]  host_color_i;
  logic        host_gnt_o;
  logic        fill_start_i;
  logic [10:0] fill_x0_i;
  logic [10:0] fill_x1_i;
  logic [10:0] fill_y0_i;
  logic [10:0] fill_y1_i;
  logic [1:0]  fill_color_i;
  logic        fill_busy_o;
  logic        fill_done_o;
  logic        fb_we_o;
  logic [10:0] fb_addr_x_o;
  logic [10:0] fb_addr_y_o;
  logic [1:0]  fb_color_o;

  fb_write_arbiter dut (
    .clk_i       (clk_i),
    .arst_i      (arst_i),
    .host_req_i  (host_req_i),
    .host_x_i    (host_x_i),
    .host_y_i    (host_y_i),
    .host_color_i(host_color_i),
    .host_gnt_o  (host_gnt_o),
    .fill_start_i(fill_start_i),
    .fill_x0_i   (fill_x0_i),
    .fill_x1_i   (fill_x1_i),
    .fill_y0_i   (fill_y0_i),
    .fill_y1_i   (fill_y1_i),
    .fill_color_i(fill_color_i),
    .fill_busy_o (fill_busy_o),
    .fill_done_o (fill_done_o),
    .fb_we_o     (fb_we_o),
    .fb_addr_x_o (fb_addr_x_o),
    .fb_addr_y_o (fb_addr_y_o),
    .fb_color_o  (fb_color_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int x;
    int y;
    int c;
  } pix_t;

  // Reference model: pending fill pixels in raster order, a done-pending flag,
  // and whose turn it is on the next contested cycle.
  pix_t m_q[$];
  bit   m_done_pend;
  bit   m_host_turn;
  bit   last_gnt;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int wr_cnt, done_cnt, busy_cnt, hg_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_q.delete();
    m_done_pend = 1'b0;
    m_host_turn = 1'b1;
    last_gnt    = 1'b0;
  endtask

  task automatic m_start(input int x0, input int x1, input int y0, input int y1, input int c);
    int  x1c, y1c;
    pix_t p;
    x1c = (x1 > HD - 1) ? HD - 1 : x1;
    y1c = (y1 > VD - 1) ? VD - 1 : y1;
    if (x0 > x1c || y0 > y1c) begin
      m_done_pend = 1'b1;
    end else begin
      for (int y = y0; y <= y1c; y++) begin
        for (int x = x0; x <= x1c; x++) begin
          p.x = x; p.y = y; p.c = c;
          m_q.push_back(p);
        end
      end
    end
  endtask

  // One clock cycle; inputs are already driven. Starts just after a rising edge.
  task automatic cycle();
    logic e_busy, e_done, e_gnt, e_fw, e_we;
    pix_t e_p;
    #1;
    e_busy = (m_q.size() > 0) || m_done_pend;
    e_done = m_done_pend && (m_q.size() == 0);
    e_gnt  = host_req_i;
    e_fw   = 1'b0;
    if (m_q.size() > 0 && host_req_i) begin
      if (m_host_turn) e_fw = 1'b0;
      else begin
        e_gnt = 1'b0;
        e_fw  = 1'b1;
      end
      m_host_turn = !m_host_turn;
    end else if (m_q.size() > 0) begin
      e_fw = 1'b1;
    end
    chk("host_gnt", host_gnt_o, e_gnt);
    chk("fill_busy", fill_busy_o, e_busy);
    chk("fill_done", fill_done_o, e_done);
    busy_cnt += int'(fill_busy_o);
    done_cnt += int'(fill_done_o);
    hg_cnt   += int'(host_gnt_o);
    e_we = 1'b0;
    e_p.x = 0; e_p.y = 0; e_p.c = 0;
    if (e_gnt) begin
      if (int'(host_x_i) < HD && int'(host_y_i) < VD) begin
        e_we = 1'b1;
        e_p.x = int'(host_x_i); e_p.y = int'(host_y_i); e_p.c = int'(host_color_i);
      end
    end else if (e_fw) begin
      e_we = 1'b1;
      e_p  = m_q.pop_front();
    end
    if (e_done) m_done_pend = 1'b0;
    if (e_fw && m_q.size() == 0) m_done_pend = 1'b1;
    if (!e_busy && fill_start_i)
      m_start(int'(fill_x0_i), int'(fill_x1_i), int'(fill_y0_i), int'(fill_y1_i), int'(fill_color_i));
    last_gnt = e_gnt;
    @(posedge clk_i);
    #1;
    chk("fb_we", fb_we_o, e_we);
    wr_cnt += int'(fb_we_o);
    if (e_we) begin
      chk("fb_x", fb_addr_x_o, e_p.x);
      chk("fb_y", fb_addr_y_o, e_p.y);
      chk("fb_color", fb_color_o, e_p.c);
    end
  endtask

  task automatic clr_cnt();
    wr_cnt = 0; done_cnt = 0; busy_cnt = 0; hg_cnt = 0;
  endtask

  task automatic set_fill(input int x0, input int x1, input int y0, input int y1, input int c);
    fill_start_i = 1'b1;
    fill_x0_i = 11'(x0); fill_x1_i = 11'(x1);
    fill_y0_i = 11'(y0); fill_y1_i = 11'(y1);
    fill_color_i = 2'(c);
  endtask

  function automatic int rnd_x();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1272, 1290)) : int'($urandom_range(0, 20));
  endfunction

  function automatic int rnd_y();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1016, 1030)) : int'($urandom_range(0, 20));
  endfunction

  initial begin
    int x0, y0, x1, y1;
    arst_i = 1'b1;
    host_req_i = 1'b0; host_x_i = '0; host_y_i = '0; host_color_i = '0;
    fill_start_i = 1'b0; fill_x0_i = '0; fill_x1_i = '0; fill_y0_i = '0; fill_y1_i = '0;
    fill_color_i = '0;
    m_reset();
    clr_cnt();

    // Reset values
    #3;
    chk("rst_we", fb_we_o, 0);
    chk("rst_x", fb_addr_x_o, 0);
    chk("rst_y", fb_addr_y_o, 0);
    chk("rst_color", fb_color_o, 0);
    chk("rst_busy", fill_busy_o, 0);
    chk("rst_done", fill_done_o, 0);
    @(posedge clk_i); #1;
    arst_i = 1'b0;

    // Host-only write, then an off-screen host write that must be dropped
    host_req_i = 1'b1; host_x_i = 11'd5; host_y_i = 11'd7; host_color_i = 2'd2;
    cycle();
    host_x_i = 11'd1280; host_y_i = 11'd5;
    cycle();
    host_req_i = 1'b0;
    cycle();

    // Small fill, with a second start while busy that must be ignored
    clr_cnt();
    set_fill(2, 4, 3, 4, 1);
    cycle();
    clr_cnt();
    fill_start_i = 1'b0;
    cycle();
    set_fill(100, 101, 100, 101, 3);
    cycle();
    fill_start_i = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
    chk("small_writes", wr_cnt, 6);
    chk("small_busy", busy_cnt, 7);
    chk("small_done", done_cnt, 1);

    // Contention: host requests three pixels while a 4-pixel fill runs
    begin
      int hg;
      hg = 0;
      clr_cnt();
      set_fill(0, 3, 0, 0, 2);
      cycle();
      fill_start_i = 1'b0;
      for (int i = 0; i < 9; i++) begin
        host_req_i   = (hg < 3);
        host_x_i     = 11'(10 + hg);
        host_y_i     = 11'd20;
        host_color_i = 2'd3;
        cycle();
        if (last_gnt) hg++;
      end
      host_req_i = 1'b0;
      chk("cont_writes", wr_cnt, 7);
      chk("cont_hgnt", hg_cnt, 3);
      chk("cont_done", done_cnt, 1);
    end

    // Clamped fill at the bottom-right corner
    clr_cnt();
    set_fill(1278, 2000, 1022, 2000, 1);
    cycle();
    fill_start_i = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
    chk("clamp_writes", wr_cnt, 4);
    chk("clamp_done", done_cnt, 1);

    // Degenerate fill: x0 > x1
    clr_cnt();
    set_fill(10, 5, 0, 0, 2);
    cycle();
    fill_start_i = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    chk("degen_writes", wr_cnt, 0);
    chk("degen_done", done_cnt, 1);

    // Reset in the middle of a fill
    set_fill(0, 99, 0, 0, 3);
    cycle();
    fill_start_i = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    arst_i = 1'b1;
    #1;
    chk("mid_rst_we", fb_we_o, 0);
    chk("mid_rst_busy", fill_busy_o, 0);
    chk("mid_rst_done", fill_done_o, 0);
    m_reset();
    @(posedge clk_i); #1;
    arst_i = 1'b0;
    clr_cnt();
    for (int i = 0; i < 110; i++) cycle();
    chk("post_rst_writes", wr_cnt, 0);
    chk("post_rst_done", done_cnt, 0);

    // Random host and fill traffic
    for (int i = 0; i < 3000; i++) begin
      if (!host_req_i || last_gnt) begin
        host_req_i   = ($urandom_range(0, 2) == 0);
        host_x_i     = 11'(rnd_x());
        host_y_i     = 11'(rnd_y());
        host_color_i = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 11) == 0) begin
        x0 = rnd_x();
        y0 = rnd_y();
        x1 = ($urandom_range(0, 4) == 0 && x0 > 0) ? x0 - 1 : x0 + int'($urandom_range(0, 4));
        y1 = ($urandom_range(0, 5) == 0 && y0 > 0) ? y0 - 1 : y0 + int'($urandom_range(0, 2));
        set_fill(x0, x1, y0, y1, int'($urandom_range(0, 3)));
      end else begin
        fill_start_i = 1'b0;
      end
      cycle();
    end
    host_req_i = 1'b0;
    fill_start_i = 1'b0;
    for (int i = 0; i < 40; i++) cycle();
    chk("drain_queue", m_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
